hdlc_framer: RTL and testbench

Serial HDLC-style framer that is the transmit-side counterpart of the team's flag/discard/error bit-stream receiver. It accepts bytes over a valid/ready handshake and emits one bit per clock with bit stuffing: a 0 after every five consecutive data 1s. It brackets frames with the flag 01111110 and fills idle time with back-to-back flags. On input underrun mid-frame it sends an abort (eight 1s), which the receiver reports as an error.

---
 rtl/hdlc_framer_pkg.sv | 15 +
 rtl/hdlc_framer.sv | 141 ++++++++++++++
 tb/tb_hdlc_framer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_framer_pkg.sv
// Constants and state type shared by the HDLC framer and its receive-side counterpart.
// The receiver uses the same values so that a loopback pair agrees on framing.
package hdlc_framer_pkg;

  localparam logic [7:0] FLAG_PATTERN = 8'h7E;
  localparam logic [2:0] STUFF_LIMIT  = 3'd5;
  localparam logic [3:0] ABORT_LEN    = 4'd8;

  typedef enum logic [1:0] {
    FLAG  = 2'd0,
    DATA  = 2'd1,
    ABORT = 2'd2
  } state_t;

endpackage

// File: rtl/hdlc_framer.sv
// HDLC transmit framer: bytes in over valid/ready, one line bit per clock out,
// with zero-bit stuffing, flag fill between frames and abort on underrun.
module hdlc_framer
  import hdlc_framer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       out,
  output logic       stuff,
  output logic       flag_out,
  output logic       underrun,
  output logic       busy
);

  localparam logic [2:0] LAST_IDX   = 3'd7;
  localparam logic [2:0] ABORT_LAST = 3'(ABORT_LEN - 4'd1);

  // The *_reg values describe the bit currently on the line.
  state_t     state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic       stuffing_reg, stuffing_next;
  logic [2:0] ones_reg, ones_next;
  logic [7:0] byte_reg, byte_next;
  logic       last_reg, last_next;
  logic       out_reg, out_next;
  logic       flag_out_reg, flag_out_next;
  logic       underrun_reg, underrun_next;
  logic       busy_reg, busy_next;

  logic stuff_due;
  logic unit_end;
  logic take;
  logic data_bit;

  // ones_reg already counts the bit on the line, so reaching the limit means the
  // following cycle must carry the stuffed 0.
  assign stuff_due = (state_reg == DATA) && (ones_reg == STUFF_LIMIT);

  always_comb begin
    unit_end = 1'b0;
    if (!stuff_due) begin
      if (state_reg == ABORT) unit_end = (idx_reg == ABORT_LAST);
      else                    unit_end = (idx_reg == LAST_IDX);
    end
  end

  assign din_ready = unit_end &&
                     ((state_reg == FLAG) || ((state_reg == DATA) && !last_reg));
  assign take      = din_ready && din_valid;

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg + 3'd1;
    stuffing_next = 1'b0;
    byte_next     = byte_reg;
    last_next     = last_reg;
    underrun_next = 1'b0;

    if (stuff_due) begin
      idx_next      = idx_reg;
      stuffing_next = 1'b1;
    end else if (unit_end) begin
      idx_next = 3'd0;
      case (state_reg)
        FLAG: begin
          if (take) begin
            state_next = DATA;
            byte_next  = din;
            last_next  = din_last;
          end
        end
        DATA: begin
          if (last_reg) begin
            state_next = FLAG;
          end else if (take) begin
            byte_next = din;
            last_next = din_last;
          end else begin
            state_next    = ABORT;
            underrun_next = 1'b1;
          end
        end
        default: state_next = FLAG;
      endcase
    end

    data_bit = LSB_FIRST ? byte_next[idx_next] : byte_next[3'd7 - idx_next];

    case (state_next)
      FLAG:    out_next = FLAG_PATTERN[idx_next];
      DATA:    out_next = stuffing_next ? 1'b0 : data_bit;
      default: out_next = 1'b1;
    endcase

    // Carries across bytes of a frame; any non-data bit clears it.
    if ((state_next == DATA) && !stuffing_next && data_bit) ones_next = ones_reg + 3'd1;
    else                                                     ones_next = 3'd0;

    flag_out_next = (state_next == FLAG) && (idx_next == LAST_IDX);
    busy_next     = (state_next != FLAG);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= FLAG;
      idx_reg      <= 3'd0;
      stuffing_reg <= 1'b0;
      ones_reg     <= 3'd0;
      byte_reg     <= 8'd0;
      last_reg     <= 1'b0;
      out_reg      <= 1'b0;
      flag_out_reg <= 1'b0;
      underrun_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      stuffing_reg <= stuffing_next;
      ones_reg     <= ones_next;
      byte_reg     <= byte_next;
      last_reg     <= last_next;
      out_reg      <= out_next;
      flag_out_reg <= flag_out_next;
      underrun_reg <= underrun_next;
      busy_reg     <= busy_next;
    end
  end

  assign out      = out_reg;
  assign stuff    = stuffing_reg;
  assign flag_out = flag_out_reg;
  assign underrun = underrun_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_hdlc_framer.sv
// Self-checking bench for hdlc_framer: a bit-level model fills an expected queue,
// the driver captures one sample per line cycle, and each test compares them.
module tb_hdlc_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = 8'd0;
  logic       din_valid = 1'b0;
  logic       din_last = 1'b0;
  logic       din_ready, out, stuff, flag_out, underrun, busy;

  always #5 clk = ~clk;

  hdlc_framer #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready), .out(out), .stuff(stuff), .flag_out(flag_out),
    .underrun(underrun), .busy(busy)
  );

  typedef struct packed {
    logic out_bit;
    logic stuff;
    logic flag;
    logic busy;
    logic ready;
    logic underrun;
  } smp_t;

  smp_t       exp_q[$];
  smp_t       got_q[$];
  logic [7:0] tx_data[$];
  logic       tx_last[$];
  int         m_ones;
  int         checks = 0;
  int         failures = 0;

  function automatic smp_t mk(logic o, logic s, logic f, logic b, logic r, logic u);
    smp_t e;
    e.out_bit = o; e.stuff = s; e.flag = f; e.busy = b; e.ready = r; e.underrun = u;
    return e;
  endfunction

  // Flag 01111110; flag_out and din_ready on its last bit.
  function automatic void push_flag();
    logic [7:0] pat;
    pat = 8'h7E;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(pat[i], 1'b0, i == 7, 1'b0, i == 7, 1'b0));
    m_ones = 0;
  endfunction

  function automatic void push_byte(logic [7:0] b, logic last);
    logic st;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) m_ones++; else m_ones = 0;
      st = (m_ones == 5);
      exp_q.push_back(mk(b[i], 1'b0, 1'b0, 1'b1, (i == 7) && !st && !last, 1'b0));
      if (st) begin
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, (i == 7) && !last, 1'b0));
        m_ones = 0;
      end
    end
    if (last) push_flag();
  endfunction

  function automatic void push_abort();
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, i == 0));
    m_ones = 0;
  endfunction

  task automatic drive_inputs();
    if (tx_data.size() > 0) begin
      din_valid = 1'b1; din = tx_data[0]; din_last = tx_last[0];
    end else begin
      din_valid = 1'b0; din = 8'd0; din_last = 1'b0;
    end
  endtask

  // Captures n line cycles, presenting queued bytes and honouring the handshake.
  task automatic run_cycles(input int n);
    logic hs;
    drive_inputs();
    for (int i = 0; i < n; i++) begin
      got_q.push_back(mk(out, stuff, flag_out, busy, din_ready, underrun));
      hs = din_valid && din_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        void'(tx_data.pop_front());
        void'(tx_last.pop_front());
      end
      drive_inputs();
    end
  endtask

  task automatic start_stream();
    reset = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_ones = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic queue_byte(input logic [7:0] b, input logic last);
    tx_data.push_back(b);
    tx_last.push_back(last);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    din_valid = 1'b1; din = 8'hFF; din_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out, stuff, flag_out, underrun, busy, din_ready} !== 6'b0) begin
        failures++;
        $display("FAIL reset_values cyc=%0d got=%b exp=000000", i,
                 {out, stuff, flag_out, underrun, busy, din_ready});
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_idle();
    int n;
    start_stream();
    for (int k = 0; k < 5; k++) push_flag();
    n = exp_q.size();
    run_cycles(n);
    for (int i = 0; i < n; i++) begin
      smp_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  task automatic test_single_zero();
    int n;
    start_stream();
    queue_byte(8'h00, 1'b1);
    push_flag(); push_byte(8'h00, 1'b1); push_flag();
    n = exp_q.size();
    run_cycles(n);
    for (int i = 0; i < n; i++) begin
      smp_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL single_zero cyc=%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  task automatic test_ones_stuff();
    int n;
    start_stream();
    queue_byte(8'hFF, 1'b1);
    push_flag(); push_byte(8'hFF, 1'b1); push_flag();
    n = exp_q.size();
    run_cycles(n);
    for (int i = 0; i < n; i++) begin
      smp_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL ones_stuff cyc=%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start_stream();
    queue_byte(8'hF8, 1'b0); queue_byte(8'h01, 1'b1);
    push_flag(); push_byte(8'hF8, 1'b0); push_byte(8'h01, 1'b1); push_flag();
    n = exp_q.size();
    run_cycles(n);
    for (int i = 0; i < n; i++) begin
      smp_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  task automatic test_long_frame();
    int n;
    logic [7:0] bytes[6];
    bytes[0] = 8'($urandom_range(0, 255)); bytes[1] = 8'hFF; bytes[2] = 8'h7E;
    bytes[3] = 8'($urandom_range(0, 255)); bytes[4] = 8'h3F; bytes[5] = 8'($urandom_range(0, 255));
    start_stream();
    push_flag();
    for (int k = 0; k < 6; k++) begin
      queue_byte(bytes[k], k == 5);
      push_byte(bytes[k], k == 5);
    end
    push_flag();
    n = exp_q.size();
    run_cycles(n);
    for (int i = 0; i < n; i++) begin
      smp_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL long_frame cyc=%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  task automatic test_underrun();
    int n;
    start_stream();
    queue_byte(8'h55, 1'b0);
    push_flag(); push_byte(8'h55, 1'b0); push_abort(); push_flag(); push_flag();
    n = exp_q.size();
    run_cycles(n);
    for (int i = 0; i < n; i++) begin
      smp_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL underrun cyc=%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    start_stream();
    queue_byte(8'h0F, 1'b1);
    push_flag(); push_byte(8'h0F, 1'b1);
    run_cycles(11);  // ends at the start of data idx 3, which carries a 1
    for (int i = 0; i < 11; i++) begin
      smp_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL mid_frame_lead cyc=%0d got=%b exp=%b", i, g, e);
      end
    end
    checks++;
    if ({out, busy} !== 2'b11) begin
      failures++;
      $display("FAIL mid_frame_pre_reset got=%b exp=11", {out, busy});
    end
    #2;
    reset = 1'b0;
    tx_data.delete(); tx_last.delete();
    drive_inputs();
    #1;
    checks++;
    if ({out, busy, stuff, din_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_frame_async got=%b exp=0000", {out, busy, stuff, din_ready});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete(); got_q.delete(); m_ones = 0;
    push_flag(); push_flag();
    n = exp_q.size();
    run_cycles(n);
    for (int i = 0; i < n; i++) begin
      smp_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL mid_frame_restart cyc=%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_zero();
    test_ones_stuff();
    test_back_to_back();
    test_long_frame();
    test_underrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
